mult_div_unit: RTL and testbench

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

---
 rtl/cpu_defs.sv | 13 +
 rtl/div_step.sv | 22 ++
 rtl/mult_div_unit.sv | 146 ++++++++++++++
 tb/tb_mult_div_unit.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_defs.sv
// Shared control-unit definitions: 2-bit FSM encoding and operation-select codes
// used by the multiply/divide unit and the CPU control path.
package cpu_defs;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MULT = 2'd1;
  localparam logic [1:0] ST_DIV  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV  = 1'b1;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration on unsigned magnitudes: shift in the next
// dividend bit, subtract the divisor if it fits, emit the quotient bit.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic [WIDTH-1:0] divisor,
  input  logic             dividend_bit,
  output logic [WIDTH-1:0] rem_out,
  output logic             q_bit
);

  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] trial;

  assign shifted = {rem_in, dividend_bit};
  assign q_bit   = shifted >= {1'b0, divisor};
  // rem_in < divisor keeps the difference below divisor, so WIDTH bits suffice
  assign trial   = shifted[WIDTH-1:0] - divisor;
  assign rem_out = q_bit ? trial : shifted[WIDTH-1:0];

endmodule

// File: rtl/mult_div_unit.sv
// Iterative signed multiply (radix-2 Booth) and divide (restoring) unit.
// Results land on hi/lo only on entry to DONE; divide by zero skips straight to DONE.
module mult_div_unit
  import cpu_defs::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_mult,
  input  logic             start_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);

  logic [1:0]         state_reg;
  logic [CNT_W-1:0]   cnt_reg;
  // Booth accumulator: {A (WIDTH+1 bits), Q (WIDTH bits), q(-1)}
  logic [2*WIDTH+1:0] acc_reg;
  logic [2*WIDTH+1:0] acc_next;
  logic [WIDTH-1:0]   m_reg;
  logic [WIDTH-1:0]   rem_reg;
  logic [WIDTH-1:0]   dvd_reg;
  logic [WIDTH-1:0]   dvs_reg;
  logic               q_neg_reg;
  logic               r_neg_reg;

  logic [WIDTH:0]     booth_a;
  logic [WIDTH:0]     booth_sum;
  logic [WIDTH:0]     m_ext;
  logic [WIDTH-1:0]   step_rem;
  logic               step_q;
  logic [WIDTH-1:0]   quo_next;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic               op_sel;
  logic               last_step;

  assign op_sel    = start_mult ? OP_MULT : OP_DIV;
  assign last_step = (cnt_reg == CNT_W'(WIDTH - 1));
  assign busy      = (state_reg == ST_MULT) || (state_reg == ST_DIV);
  assign a_mag     = a[WIDTH-1] ? -a : a;
  assign b_mag     = b[WIDTH-1] ? -b : b;

  assign booth_a = acc_reg[2*WIDTH+1:WIDTH+1];
  assign m_ext   = {m_reg[WIDTH-1], m_reg};

  always_comb begin
    booth_sum = booth_a;
    case (acc_reg[1:0])
      2'b01:   booth_sum = booth_a + m_ext;
      2'b10:   booth_sum = booth_a - m_ext;
      default: booth_sum = booth_a;
    endcase
  end

  // Arithmetic shift right of the whole accumulator after the add/subtract
  assign acc_next = {booth_sum[WIDTH], booth_sum, acc_reg[WIDTH:1]};

  div_step #(.WIDTH(WIDTH)) u_div_step (
    .rem_in       (rem_reg),
    .divisor      (dvs_reg),
    .dividend_bit (dvd_reg[WIDTH-1]),
    .rem_out      (step_rem),
    .q_bit        (step_q)
  );

  // The dividend register doubles as the quotient: bits shift out at the top, in at the bottom
  assign quo_next = {dvd_reg[WIDTH-2:0], step_q};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      acc_reg   <= '0;
      m_reg     <= '0;
      rem_reg   <= '0;
      dvd_reg   <= '0;
      dvs_reg   <= '0;
      q_neg_reg <= 1'b0;
      r_neg_reg <= 1'b0;
      hi        <= '0;
      lo        <= '0;
      done      <= 1'b0;
      div_zero  <= 1'b0;
    end else begin
      done     <= 1'b0;
      div_zero <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (start_mult || start_div) begin
            cnt_reg   <= '0;
            acc_reg   <= {{(WIDTH+1){1'b0}}, a, 1'b0};
            m_reg     <= b;
            rem_reg   <= '0;
            dvd_reg   <= a_mag;
            dvs_reg   <= b_mag;
            q_neg_reg <= a[WIDTH-1] ^ b[WIDTH-1];
            r_neg_reg <= a[WIDTH-1];
            if (op_sel == OP_MULT) begin
              state_reg <= ST_MULT;
            end else if (b == '0) begin
              state_reg <= ST_DONE;
              done      <= 1'b1;
              div_zero  <= 1'b1;
            end else begin
              state_reg <= ST_DIV;
            end
          end
        end
        ST_MULT: begin
          acc_reg <= acc_next;
          cnt_reg <= cnt_reg + 1'b1;
          if (last_step) begin
            hi        <= acc_next[2*WIDTH:WIDTH+1];
            lo        <= acc_next[WIDTH:1];
            done      <= 1'b1;
            state_reg <= ST_DONE;
          end
        end
        ST_DIV: begin
          rem_reg <= step_rem;
          dvd_reg <= quo_next;
          cnt_reg <= cnt_reg + 1'b1;
          if (last_step) begin
            lo        <= q_neg_reg ? -quo_next : quo_next;
            hi        <= r_neg_reg ? -step_rem : step_rem;
            done      <= 1'b1;
            state_reg <= ST_DONE;
          end
        end
        default: begin
          cnt_reg   <= '0;
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit (WIDTH=32): directed corners plus random
// operations compared against plain signed 64-bit arithmetic.
module tb_mult_div_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start_mult = 1'b0;
  logic         start_div = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [W-1:0] hi;
  logic [W-1:0] lo;
  logic         busy;
  logic         done;
  logic         div_zero;

  int checks = 0;
  int failures = 0;

  // Values the model says are currently visible on hi/lo
  logic [W-1:0] cur_hi = '0;
  logic [W-1:0] cur_lo = '0;
  logic [W-1:0] pend_a = '0;
  logic [W-1:0] pend_b = '0;

  mult_div_unit #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start_mult (start_mult),
    .start_div  (start_div),
    .a          (a),
    .b          (b),
    .hi         (hi),
    .lo         (lo),
    .busy       (busy),
    .done       (done),
    .div_zero   (div_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: signed 64-bit arithmetic; SV division truncates toward zero and
  // the remainder takes the dividend's sign, which is exactly the required behaviour.
  task automatic model_op(input bit is_mult, input logic [W-1:0] ma, input logic [W-1:0] mb,
                          output logic [W-1:0] eh, output logic [W-1:0] el,
                          output int lat, output bit dz);
    longint sa;
    longint sb;
    logic [63:0] p;
    sa  = longint'($signed(ma));
    sb  = longint'($signed(mb));
    dz  = 1'b0;
    lat = W + 1;
    eh  = cur_hi;
    el  = cur_lo;
    if (is_mult) begin
      p  = 64'(sa * sb);
      eh = p[2*W-1:W];
      el = p[W-1:0];
    end else if (sb == 0) begin
      dz  = 1'b1;
      lat = 1;
    end else begin
      p  = 64'(sa / sb);
      el = p[W-1:0];
      p  = 64'(sa % sb);
      eh = p[W-1:0];
    end
  endtask

  // Entered #1 after an edge; k numbers the edge that would next sample done
  // (k=1 is the first edge after the start edge).
  task automatic wait_done(input string tag, input int k0, input logic [W-1:0] eh,
                           input logic [W-1:0] el, input int lat, input bit dz,
                           input bit restart);
    int k;
    bit moved;
    k = k0;
    moved = 1'b0;
    while (done !== 1'b1 && k < 3 * W) begin
      if (hi !== cur_hi || lo !== cur_lo) moved = 1'b1;
      @(posedge clk);
      #1;
      k++;
    end
    check({tag, "/hold"}, 64'(moved), 64'(0));
    check({tag, "/latency"}, 64'(k), 64'(lat));
    check({tag, "/hi"}, 64'(hi), 64'(eh));
    check({tag, "/lo"}, 64'(lo), 64'(el));
    check({tag, "/div_zero"}, 64'(div_zero), 64'(dz));
    check({tag, "/busy_done"}, 64'(busy), 64'(0));
    $display("op %s -> hi=0x%08h lo=0x%08h div_zero=%0b latency=%0d", tag, hi, lo, div_zero, k);
    cur_hi = eh;
    cur_lo = el;
    if (restart) begin
      a = pend_a;
      b = pend_b;
      start_mult = 1'b1;
    end
    @(posedge clk);
    #1;
    check({tag, "/done_pulse"}, 64'(done), 64'(0));
    check({tag, "/dz_pulse"}, 64'(div_zero), 64'(0));
  endtask

  task automatic run_op(input string tag, input bit sm, input bit sd,
                        input logic [W-1:0] ta, input logic [W-1:0] tb_v);
    logic [W-1:0] eh;
    logic [W-1:0] el;
    int lat;
    bit dz;
    model_op(sm, ta, tb_v, eh, el, lat, dz);
    a = ta;
    b = tb_v;
    start_mult = sm;
    start_div = sd;
    @(posedge clk);
    #1;
    start_mult = 1'b0;
    start_div = 1'b0;
    a = $urandom;
    b = $urandom;
    check({tag, "/busy"}, 64'(busy), 64'(dz ? 0 : 1));
    wait_done(tag, 1, eh, el, lat, dz, 1'b0);
  endtask

  initial begin
    logic [W-1:0] eh;
    logic [W-1:0] el;
    int lat;
    int seen;
    bit dz;

    #2 rst = 1'b1;
    #10;
    check("reset/hi", 64'(hi), 64'(0));
    check("reset/lo", 64'(lo), 64'(0));
    check("reset/busy", 64'(busy), 64'(0));
    check("reset/done", 64'(done), 64'(0));
    check("reset/div_zero", 64'(div_zero), 64'(0));
    @(negedge clk);
    rst = 1'b0;

    // First start lands on the first edge after reset release
    run_op("mul_7_m3", 1'b1, 1'b0, 32'd7, 32'hFFFF_FFFD);
    run_op("mul_minmin", 1'b1, 1'b0, 32'h8000_0000, 32'h8000_0000);
    run_op("div_ovf", 1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op("div_m7_2", 1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2);
    run_op("div_zero", 1'b0, 1'b1, 32'd5, 32'd0);
    run_op("both_starts", 1'b1, 1'b1, 32'd1234, 32'hFFFF_FFC8);

    // Start held through DONE: ignored there, accepted in the next IDLE cycle
    model_op(1'b0, 32'd100, 32'd7, eh, el, lat, dz);
    a = 32'd100;
    b = 32'd7;
    start_div = 1'b1;
    @(posedge clk);
    #1;
    start_div = 1'b0;
    pend_a = 32'hFFFF_FF00;
    pend_b = 32'd300;
    wait_done("div_100_7", 1, eh, el, lat, dz, 1'b1);
    check("done_start/ignored", 64'(busy), 64'(0));
    model_op(1'b1, pend_a, pend_b, eh, el, lat, dz);
    @(posedge clk);
    #1;
    start_mult = 1'b0;
    a = $urandom;
    b = $urandom;
    check("done_start/accepted", 64'(busy), 64'(1));
    wait_done("mul_after_done", 1, eh, el, lat, dz, 1'b0);

    // Divide request pulsed mid-multiply must be dropped
    model_op(1'b1, 32'h0001_2345, 32'hFFFE_0001, eh, el, lat, dz);
    a = 32'h0001_2345;
    b = 32'hFFFE_0001;
    start_mult = 1'b1;
    @(posedge clk);
    #1;
    start_mult = 1'b0;
    a = 32'd5;
    b = 32'd0;
    repeat (4) @(posedge clk);
    #1;
    start_div = 1'b1;
    @(posedge clk);
    #1;
    start_div = 1'b0;
    wait_done("mul_poked", 6, eh, el, lat, dz, 1'b0);

    for (int i = 0; i < 12; i++) begin
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      ra = $urandom;
      rb = (i % 4 == 3) ? W'($urandom_range(1, 20)) : W'($urandom);
      if (i % 6 == 5) ra = W'($urandom_range(0, 1000));
      run_op($sformatf("rnd%0d", i), (i % 2) == 0, (i % 2) == 1, ra, rb);
    end

    // Reset at cycle 10 of a multiply aborts it
    a = 32'd11;
    b = 32'd13;
    start_mult = 1'b1;
    @(posedge clk);
    #1;
    start_mult = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("abort/busy", 64'(busy), 64'(0));
    check("abort/hi", 64'(hi), 64'(0));
    check("abort/lo", 64'(lo), 64'(0));
    check("abort/done", 64'(done), 64'(0));
    cur_hi = '0;
    cur_lo = '0;
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) seen++;
    end
    check("abort/no_done", 64'(seen), 64'(0));
    check("abort/hi_after", 64'(hi), 64'(cur_hi));
    check("abort/lo_after", 64'(lo), 64'(cur_lo));
    $display("op abort -> done pulses after reset=%0d", seen);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
